// File: rtl/recirc_ctrl.sv
// Control FSM for the 4-lane recirculator: loops traffic back while idle, routes it to the
// datapath while active. Optional activity counter enabled by RECIRC_CTRL_STATS_EN.
module recirc_ctrl #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [CNT_W-1:0] thr_in,
  input  logic [LANES-1:0] valid_in,
  input  logic [LANES-1:0] fifo_empty,
  input  logic [LANES-1:0] fifo_almost_full,
  input  logic [LANES-1:0] fifo_full,
  output logic             selector_idle,
  output logic             idle_out,
  output logic             active_out,
  output logic             pause_out,
  output logic             err_out,
  output logic [2:0]       state_out,
  output logic [15:0]      active_cycles
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic             pause_q, pause_d;

  logic             afull_any;
  logic             overflow;
  logic             quiet;
  logic [CNT_W:0]   cnt_inc;

  assign afull_any = |fifo_almost_full;
  assign overflow  = |(valid_in & fifo_full);
  assign quiet     = (valid_in == '0) && (&fifo_empty);
  // One bit wider so the threshold compare cannot wrap.
  assign cnt_inc   = {1'b0, quiet_cnt_q} + (CNT_W + 1)'(1);

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    quiet_cnt_d = quiet_cnt_q;
    pause_d     = (state_q != StReset) ? afull_any : 1'b0;

    case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        thr_d = (thr_in == '0) ? CNT_W'(1) : thr_in;
        if (!init) state_d = StIdle;
      end
      StIdle: begin
        if (init) begin
          state_d = StInit;
        end else if (|valid_in && !afull_any) begin
          state_d     = StActive;
          quiet_cnt_d = '0;
        end
      end
      StActive: begin
        if (overflow) begin
          state_d     = StError;
          quiet_cnt_d = '0;
        end else if (init) begin
          state_d     = StInit;
          quiet_cnt_d = '0;
        end else if (quiet) begin
          if (cnt_inc == {1'b0, thr_q}) begin
            state_d     = StIdle;
            quiet_cnt_d = '0;
          end else if (quiet_cnt_q != '1) begin
            quiet_cnt_d = cnt_inc[CNT_W-1:0];
          end
        end else begin
          quiet_cnt_d = '0;
        end
      end
      StError: state_d = StError;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReset;
      thr_q       <= CNT_W'(IDLE_CYCLES);
      quiet_cnt_q <= '0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      quiet_cnt_q <= quiet_cnt_d;
      pause_q     <= pause_d;
    end
  end

  assign selector_idle = (state_q == StActive);
  assign idle_out      = (state_q == StIdle);
  assign active_out    = (state_q == StActive);
  assign err_out       = (state_q == StError);
  assign pause_out     = pause_q;
  assign state_out     = state_q;

`ifdef RECIRC_CTRL_STATS_EN
  logic [15:0] act_cnt_q, act_cnt_d;

  always_comb begin
    act_cnt_d = act_cnt_q;
    if (state_q == StInit) begin
      act_cnt_d = '0;
    end else if (state_q == StActive && act_cnt_q != 16'hFFFF) begin
      act_cnt_d = act_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) act_cnt_q <= '0;
    else       act_cnt_q <= act_cnt_d;
  end

  assign active_cycles = act_cnt_q;
`else
  assign active_cycles = '0;
`endif

endmodule

// File: tb/tb_recirc_ctrl.sv
// Scoreboard bench for recirc_ctrl: each driven cycle pushes the expected outputs, which are
// popped and compared once the following clock edge has updated the DUT.
module tb_recirc_ctrl;

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_INI = 3'd1;
  localparam logic [2:0] S_IDL = 3'd2;
  localparam logic [2:0] S_ACT = 3'd3;
  localparam logic [2:0] S_ERR = 3'd4;

  typedef struct packed {
    logic       rst;
    logic       ini;
    logic [3:0] thr;
    logic [3:0] v;
    logic [3:0] e;
    logic [3:0] af;
    logic [3:0] f;
    logic [2:0] st;
    logic       p;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [3:0]  thr_in;
  logic [3:0]  valid_in;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_almost_full;
  logic [3:0]  fifo_full;
  logic        selector_idle;
  logic        idle_out;
  logic        active_out;
  logic        pause_out;
  logic        err_out;
  logic [2:0]  state_out;
  logic [15:0] active_cycles;

  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  recirc_ctrl #(
    .LANES       (4),
    .CNT_W       (4),
    .IDLE_CYCLES (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .thr_in           (thr_in),
    .valid_in         (valid_in),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .selector_idle    (selector_idle),
    .idle_out         (idle_out),
    .active_out       (active_out),
    .pause_out        (pause_out),
    .err_out          (err_out),
    .state_out        (state_out),
    .active_cycles    (active_cycles)
  );

  // {state_out, selector_idle, idle_out, active_out, pause_out, err_out}
  function automatic logic [7:0] ev(input logic [2:0] st, input logic p);
    ev = {st, st == S_ACT, st == S_IDL, st == S_ACT, p, st == S_ERR};
  endfunction

  function automatic step_t mk(input logic r, input logic i, input logic [3:0] th,
                               input logic [3:0] v, input logic [3:0] e, input logic [3:0] af,
                               input logic [3:0] f, input logic [2:0] st, input logic p);
    mk = '{rst: r, ini: i, thr: th, v: v, e: e, af: af, f: f, st: st, p: p};
  endfunction

  function automatic step_t quiet_step(input logic [2:0] st);
    quiet_step = mk(1'b0, 1'b0, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, st, 1'b0);
  endfunction

  function automatic step_t valid_step(input logic [3:0] v, input logic [2:0] st);
    valid_step = mk(1'b0, 1'b0, 4'd3, v, 4'hE, 4'h0, 4'h0, st, 1'b0);
  endfunction

  task automatic apply(input step_t s);
    reset            = s.rst;
    init             = s.ini;
    thr_in           = s.thr;
    valid_in         = s.v;
    fifo_empty       = s.e;
    fifo_almost_full = s.af;
    fifo_full        = s.f;
    exp_q.push_back(ev(s.st, s.p));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] observed();
    observed = {state_out, selector_idle, idle_out, active_out, pause_out, err_out};
  endfunction

  task automatic test_reset();
    step_t t[$];
    logic [7:0] want;
    t.push_back(mk(1'b1, 1'b0, 4'd3, 4'h0, 4'hF, 4'h8, 4'h0, S_RST, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_RST, 1'b0));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL reset step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_init();
    step_t t[$];
    logic [7:0] want;
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(quiet_step(S_IDL));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL init step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_quiet_return();
    step_t t[$];
    logic [7:0] want;
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_IDL));
    // A non-empty downstream FIFO breaks the quiet run.
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(mk(1'b0, 1'b0, 4'd3, 4'h0, 4'h7, 4'h0, 4'h0, S_ACT, 1'b0));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL quiet_return step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_requalify();
    step_t t[$];
    logic [7:0] want;
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(valid_step(4'b0100, S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL requalify step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_init_priority();
    step_t t[$];
    logic [7:0] want;
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h1, 4'hE, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(quiet_step(S_IDL));
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL init_priority step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_pause();
    step_t t[$];
    logic [7:0] want;
    t.push_back(mk(1'b0, 1'b0, 4'd3, 4'hF, 4'h0, 4'h8, 4'h0, S_IDL, 1'b1));
    t.push_back(mk(1'b0, 1'b0, 4'd3, 4'hF, 4'h0, 4'h8, 4'h0, S_IDL, 1'b1));
    t.push_back(quiet_step(S_IDL));
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(mk(1'b0, 1'b0, 4'd3, 4'h1, 4'hE, 4'h4, 4'h0, S_ACT, 1'b1));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_ACT));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL pause step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  task automatic test_thr_clamp();
    step_t t[$];
    step_t r[$];
    logic [7:0]  want;
    logic [15:0] want_cnt;
    t.push_back(mk(1'b0, 1'b1, 4'd0, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 4'd0, 4'h0, 4'hF, 4'h0, 4'h0, S_IDL, 1'b0));
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL thr_clamp step%0d got=%b want=%b", k, observed(), want);
      end
    end
`ifdef RECIRC_CTRL_STATS_EN
    want_cnt = 16'd2;
`else
    want_cnt = 16'd0;
`endif
    checks++;
    if (active_cycles !== want_cnt) begin
      errors++;
      $display("FAIL active_cycles got=%0d want=%0d", active_cycles, want_cnt);
    end
    r.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    r.push_back(quiet_step(S_IDL));
    foreach (r[k]) begin
      apply(r[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL thr_restore step%0d got=%b want=%b", k, observed(), want);
      end
    end
    checks++;
    if (active_cycles !== 16'd0) begin
      errors++;
      $display("FAIL active_cycles_clear got=%0d want=0", active_cycles);
    end
  endtask

  task automatic test_error();
    step_t t[$];
    logic [7:0] want;
    t.push_back(valid_step(4'b0001, S_ACT));
    t.push_back(mk(1'b0, 1'b0, 4'd3, 4'h1, 4'hE, 4'h0, 4'h2, S_ACT, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h2, 4'hD, 4'h0, 4'h2, S_ERR, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_ERR, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h8, 4'h0, S_ERR, 1'b1));
    t.push_back(quiet_step(S_ERR));
    t.push_back(mk(1'b1, 1'b0, 4'd3, 4'h0, 4'hF, 4'h8, 4'h0, S_RST, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 4'd3, 4'h0, 4'hF, 4'h0, 4'h0, S_INI, 1'b0));
    t.push_back(quiet_step(S_IDL));
    foreach (t[k]) begin
      apply(t[k]);
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL error step%0d got=%b want=%b", k, observed(), want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    init             = 1'b0;
    thr_in           = 4'd3;
    valid_in         = 4'h0;
    fifo_empty       = 4'hF;
    fifo_almost_full = 4'h0;
    fifo_full        = 4'h0;
    test_reset();
    test_init();
    test_quiet_return();
    test_requalify();
    test_init_priority();
    test_pause();
    test_thr_clamp();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
